// File: rtl/mac_jobq_package.sv
// Shared types and default widths for the MAC job scheduler.
// Perf counter option: define MAC_JOBQ_PERF_EN to enable busy_cycles_o.
package mac_jobq_package;

    localparam int JOBQ_DEPTH   = 4;
    localparam int JOBQ_ADDR_W  = 32;
    localparam int JOBQ_LEN_W   = 16;
    localparam int JOBQ_SHIFT_W = 5;

    // Job descriptor at the default widths.
    typedef struct packed {
        logic [JOBQ_ADDR_W-1:0]  a_addr;
        logic [JOBQ_ADDR_W-1:0]  b_addr;
        logic [JOBQ_ADDR_W-1:0]  c_addr;
        logic [JOBQ_ADDR_W-1:0]  d_addr;
        logic [JOBQ_LEN_W-1:0]   len;
        logic [JOBQ_SHIFT_W-1:0] shift;
        logic                    simple_mul;
    } mac_job_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2
    } jobq_state_t;

endpackage

// File: rtl/mac_jobq_fifo.sv
// Circular job buffer; pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate occupancy register.
module mac_jobq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic [W-1:0]  rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [PW:0]   count_o
);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         wr;
    logic         rd;

    assign wr = wr_en_i & ~full_o;
    assign rd = rd_en_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (wr && !clear_i) mem[wr_ptr[PW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = mem[rd_ptr[PW-1:0]];
    assign empty_o   = (wr_ptr == rd_ptr);
    assign full_o    = (wr_ptr[PW] != rd_ptr[PW]) &&
                       (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count_o   = wr_ptr - rd_ptr;

endmodule

// File: rtl/mac_job_scheduler.sv
// Queues MAC job descriptors and dispatches them one at a time to the MAC
// controller. Optional busy-cycle counter under MAC_JOBQ_PERF_EN.
module mac_job_scheduler
    import mac_jobq_package::*;
#(
    parameter int DEPTH   = JOBQ_DEPTH,
    parameter int ADDR_W  = JOBQ_ADDR_W,
    parameter int LEN_W   = JOBQ_LEN_W,
    parameter int SHIFT_W = JOBQ_SHIFT_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               push_valid_i,
    output logic               push_ready_o,
    input  logic [ADDR_W-1:0]  push_a_addr_i,
    input  logic [ADDR_W-1:0]  push_b_addr_i,
    input  logic [ADDR_W-1:0]  push_c_addr_i,
    input  logic [ADDR_W-1:0]  push_d_addr_i,
    input  logic [LEN_W-1:0]   push_len_i,
    input  logic [SHIFT_W-1:0] push_shift_i,
    input  logic               push_simple_mul_i,
    output logic               job_start_o,
    output logic [ADDR_W-1:0]  job_a_addr_o,
    output logic [ADDR_W-1:0]  job_b_addr_o,
    output logic [ADDR_W-1:0]  job_c_addr_o,
    output logic [ADDR_W-1:0]  job_d_addr_o,
    output logic [LEN_W-1:0]   job_len_o,
    output logic [SHIFT_W-1:0] job_shift_o,
    output logic               job_simple_mul_o,
    input  logic               job_done_i,
    output logic               busy_o,
    output logic               evt_o,
    output logic [CNT_W-1:0]   pending_o,
    output logic [15:0]        done_cnt_o,
    output logic               err_zero_len_o,
    output logic [31:0]        busy_cycles_o
);

    // Same layout as mac_job_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0]  a_addr;
        logic [ADDR_W-1:0]  b_addr;
        logic [ADDR_W-1:0]  c_addr;
        logic [ADDR_W-1:0]  d_addr;
        logic [LEN_W-1:0]   len;
        logic [SHIFT_W-1:0] shift;
        logic               simple_mul;
    } job_t;

    jobq_state_t state;
    job_t        push_job;
    job_t        head_job;
    job_t        job_q;
    logic        rdy_q;
    logic        full;
    logic        empty;
    logic        push_fire;
    logic        push_wr;
    logic        done_ok;
    logic        pop;

    assign push_job = '{a_addr: push_a_addr_i, b_addr: push_b_addr_i,
                        c_addr: push_c_addr_i, d_addr: push_d_addr_i,
                        len: push_len_i, shift: push_shift_i,
                        simple_mul: push_simple_mul_i};

    // rdy_q keeps ready low while reset is held and for the edge releasing it.
    assign push_ready_o = rdy_q & ~full;
    assign push_fire    = push_valid_i & push_ready_o;
    assign push_wr      = push_fire & (push_len_i != '0);
    assign done_ok      = (state == RUN) & job_done_i;
    assign pop          = ~empty & ((state == IDLE) | done_ok);

    mac_jobq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(job_t))
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .wr_en_i   (push_wr),
        .wr_data_i (push_job),
        .rd_en_i   (pop),
        .rd_data_o (head_job),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (pending_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            job_q          <= '0;
            job_start_o    <= 1'b0;
            evt_o          <= 1'b0;
            done_cnt_o     <= '0;
            err_zero_len_o <= 1'b0;
            rdy_q          <= 1'b0;
        end else if (clear_i) begin
            state          <= IDLE;
            job_q          <= '0;
            job_start_o    <= 1'b0;
            evt_o          <= 1'b0;
            done_cnt_o     <= '0;
            err_zero_len_o <= 1'b0;
            rdy_q          <= 1'b1;
        end else begin
            rdy_q       <= 1'b1;
            job_start_o <= pop;
            evt_o       <= done_ok;
            if (done_ok) done_cnt_o <= done_cnt_o + 16'd1;
            if (push_fire && (push_len_i == '0)) err_zero_len_o <= 1'b1;
            if (pop) job_q <= head_job;
            unique case (state)
                IDLE:    if (pop) state <= ISSUE;
                ISSUE:   state <= RUN;
                RUN:     if (done_ok) state <= pop ? ISSUE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o           = (state != IDLE);
    assign job_a_addr_o     = job_q.a_addr;
    assign job_b_addr_o     = job_q.b_addr;
    assign job_c_addr_o     = job_q.c_addr;
    assign job_d_addr_o     = job_q.d_addr;
    assign job_len_o        = job_q.len;
    assign job_shift_o      = job_q.shift;
    assign job_simple_mul_o = job_q.simple_mul;

`ifdef MAC_JOBQ_PERF_EN
    logic [31:0] busy_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_cnt <= '0;
        end else if (clear_i) begin
            busy_cnt <= '0;
        end else if (busy_o && (busy_cnt != '1)) begin
            busy_cnt <= busy_cnt + 32'd1;
        end
    end

    assign busy_cycles_o = busy_cnt;
`else
    assign busy_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Bench for mac_job_scheduler: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of the scheduler.
module tb_mac_job_scheduler;
    import mac_jobq_package::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        push_valid_i = 1'b0;
    logic        push_ready_o;
    logic [31:0] push_a_addr_i = '0, push_b_addr_i = '0;
    logic [31:0] push_c_addr_i = '0, push_d_addr_i = '0;
    logic [15:0] push_len_i = '0;
    logic [4:0]  push_shift_i = '0;
    logic        push_simple_mul_i = 1'b0;
    logic        job_start_o;
    logic [31:0] job_a_addr_o, job_b_addr_o, job_c_addr_o, job_d_addr_o;
    logic [15:0] job_len_o;
    logic [4:0]  job_shift_o;
    logic        job_simple_mul_o;
    logic        job_done_i = 1'b0;
    logic        busy_o;
    logic        evt_o;
    logic [2:0]  pending_o;
    logic [15:0] done_cnt_o;
    logic        err_zero_len_o;
    logic [31:0] busy_cycles_o;

    int checks = 0;
    int errors = 0;

    // Reference model: queued jobs, the active job, and the observable flags.
    mac_job_t        q[$];
    mac_job_t        m_job;
    bit              m_rdy, m_busy, m_start, m_evt, m_err;
    logic [15:0]     m_cnt;
    longint unsigned m_bc;

    mac_job_scheduler dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_a_addr_i(push_a_addr_i), .push_b_addr_i(push_b_addr_i),
        .push_c_addr_i(push_c_addr_i), .push_d_addr_i(push_d_addr_i),
        .push_len_i(push_len_i), .push_shift_i(push_shift_i),
        .push_simple_mul_i(push_simple_mul_i),
        .job_start_o(job_start_o),
        .job_a_addr_o(job_a_addr_o), .job_b_addr_o(job_b_addr_o),
        .job_c_addr_o(job_c_addr_o), .job_d_addr_o(job_d_addr_o),
        .job_len_o(job_len_o), .job_shift_o(job_shift_o),
        .job_simple_mul_o(job_simple_mul_o),
        .job_done_i(job_done_i), .busy_o(busy_o), .evt_o(evt_o),
        .pending_o(pending_o), .done_cnt_o(done_cnt_o),
        .err_zero_len_o(err_zero_len_o), .busy_cycles_o(busy_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic mac_job_t rand_job(input logic [15:0] len);
        mac_job_t j;
        j.a_addr     = $urandom;
        j.b_addr     = $urandom;
        j.c_addr     = $urandom;
        j.d_addr     = $urandom;
        j.len        = len;
        j.shift      = 5'($urandom_range(0, 31));
        j.simple_mul = 1'($urandom_range(0, 1));
        return j;
    endfunction

    task automatic drive_push(input mac_job_t j);
        push_valid_i      = 1'b1;
        push_a_addr_i     = j.a_addr;
        push_b_addr_i     = j.b_addr;
        push_c_addr_i     = j.c_addr;
        push_d_addr_i     = j.d_addr;
        push_len_i        = j.len;
        push_shift_i      = j.shift;
        push_simple_mul_i = j.simple_mul;
    endtask

    function automatic void model_reset(input bit rdy);
        q.delete();
        m_job   = '0;
        m_rdy   = rdy;
        m_busy  = 0;
        m_start = 0;
        m_evt   = 0;
        m_err   = 0;
        m_cnt   = '0;
        m_bc    = 0;
    endfunction

    // What the scheduler should look like after the coming clock edge.
    function automatic void model_step();
        bit       acc, done_ok, take;
        mac_job_t in;
        if (rst_i) begin
            model_reset(0);
        end else if (clear_i) begin
            model_reset(1);
        end else begin
            in = '{a_addr: push_a_addr_i, b_addr: push_b_addr_i, c_addr: push_c_addr_i,
                   d_addr: push_d_addr_i, len: push_len_i, shift: push_shift_i,
                   simple_mul: push_simple_mul_i};
            acc     = push_valid_i && m_rdy && (q.size() < DEPTH);
            done_ok = m_busy && !m_start && job_done_i;
            take    = (q.size() > 0) && (!m_busy || done_ok);
            if (m_busy && m_bc < 64'hFFFF_FFFF) m_bc++;
            m_evt = done_ok;
            if (done_ok) m_cnt = m_cnt + 16'd1;
            if (take) m_job = q.pop_front();
            m_start = take;
            m_busy  = take || (m_busy && !done_ok);
            if (acc) begin
                if (in.len == 0) m_err = 1;
                else q.push_back(in);
            end
            m_rdy = 1;
        end
    endfunction

    task automatic compare_all();
        mac_job_t obs;
        obs = '{a_addr: job_a_addr_o, b_addr: job_b_addr_o, c_addr: job_c_addr_o,
                d_addr: job_d_addr_o, len: job_len_o, shift: job_shift_o,
                simple_mul: job_simple_mul_o};
        chk("push_ready", push_ready_o, m_rdy && (q.size() < DEPTH));
        chk("job_start", job_start_o, m_start);
        chk("busy", busy_o, m_busy);
        chk("evt", evt_o, m_evt);
        chk("pending", pending_o, q.size());
        chk("done_cnt", done_cnt_o, m_cnt);
        chk("err_zero_len", err_zero_len_o, m_err);
`ifdef MAC_JOBQ_PERF_EN
        chk("busy_cycles", busy_cycles_o, m_bc);
`else
        chk("busy_cycles", busy_cycles_o, 0);
`endif
        checks++;
        assert (obs === m_job) else begin
            errors++;
            $error("FAIL job_fields: got %h expected %h", obs, m_job);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic do_clear();
        push_valid_i = 0;
        job_done_i   = 0;
        clear_i      = 1;
        cycle();
        clear_i      = 0;
    endtask

    // Acts as the MAC controller until everything queued has completed.
    task automatic drain(input int budget);
        int n;
        n = 0;
        push_valid_i = 0;
        while ((m_busy || q.size() > 0) && n < budget) begin
            job_done_i = m_busy && !m_start && ($urandom_range(0, 1) == 0);
            cycle();
            n++;
        end
        job_done_i = 0;
        chk("drain_idle", {busy_o, pending_o}, 0);
    endtask

    // One job running, then DEPTH more pushed so the queue ends up full.
    task automatic fill_while_running();
        drive_push(rand_job(16'd6));
        cycle();
        push_valid_i = 0;
        cycle();
        chk("fill_start", job_start_o, 1);
        for (int i = 0; i < DEPTH; i++) begin
            drive_push(rand_job(16'(3 + i)));
            cycle();
        end
        push_valid_i = 0;
        chk("fill_ready_low", push_ready_o, 0);
        chk("fill_pending", pending_o, DEPTH);
    endtask

    initial begin
        mac_job_t j;
        model_reset(0);

        // Reset state
        repeat (2) cycle();
        chk("rst_ready", push_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done_cnt", done_cnt_o, 0);
        rst_i = 0;
        cycle();
        chk("rst_release_ready", push_ready_o, 1);

        // 1: single job latency and completion
        j = rand_job(16'd8);
        j.shift = 5'd2;
        drive_push(j);
        cycle();
        push_valid_i = 0;
        chk("t1_no_start_t1", job_start_o, 0);
        cycle();
        chk("t1_start_t2", job_start_o, 1);
        chk("t1_len", job_len_o, 8);
        chk("t1_shift", job_shift_o, 2);
        repeat (3) cycle();
        job_done_i = 1;
        cycle();
        job_done_i = 0;
        chk("t1_evt", evt_o, 1);
        chk("t1_done_cnt", done_cnt_o, 1);
        chk("t1_idle", busy_o, 0);
        chk("t1_len_held", job_len_o, 8);

        // 2: five jobs in order, full at 4 pending
        do_clear();
        fill_while_running();
        drain(400);
        chk("t2_done_cnt", done_cnt_o, 5);

        // 5: push attempted in the same cycle as a pop from a full queue
        do_clear();
        fill_while_running();
        drive_push(rand_job(16'd11));
        job_done_i = 1;
        cycle();
        job_done_i = 0;
        chk("t5_evt", evt_o, 1);
        chk("t5_restart", job_start_o, 1);
        chk("t5_pending3", pending_o, 3);
        cycle();
        push_valid_i = 0;
        chk("t5_pending4", pending_o, 4);
        drain(400);
        chk("t5_done_cnt", done_cnt_o, 6);

        // 3: zero-length job is dropped, flag sticks
        do_clear();
        drive_push(rand_job(16'd0));
        cycle();
        drive_push(rand_job(16'd4));
        cycle();
        push_valid_i = 0;
        chk("t3_err", err_zero_len_o, 1);
        drain(200);
        chk("t3_err_sticky", err_zero_len_o, 1);
        chk("t3_len", job_len_o, 4);
        chk("t3_done_cnt", done_cnt_o, 1);

        // 4: clear mid-run with two pending, then a stray done
        for (int i = 0; i < 3; i++) begin
            drive_push(rand_job(16'(5 + i)));
            cycle();
        end
        push_valid_i = 0;
        chk("t4_pending2", pending_o, 2);
        chk("t4_busy", busy_o, 1);
        do_clear();
        chk("t4_busy0", busy_o, 0);
        chk("t4_pending0", pending_o, 0);
        chk("t4_done_cnt0", done_cnt_o, 0);
        chk("t4_job_a0", job_a_addr_o, 0);
        chk("t4_len0", job_len_o, 0);
        job_done_i = 1;
        cycle();
        job_done_i = 0;
        chk("t4_stray_cnt", done_cnt_o, 0);
        chk("t4_stray_evt", evt_o, 0);

        // 6: one job busy for exactly 10 cycles
        do_clear();
        drive_push(rand_job(16'd10));
        cycle();
        push_valid_i = 0;
        repeat (10) cycle();
        job_done_i = 1;
        cycle();
        job_done_i = 0;
`ifdef MAC_JOBQ_PERF_EN
        chk("t6_busy_cycles", busy_cycles_o, 10);
`else
        chk("t6_busy_cycles", busy_cycles_o, 0);
`endif

        // Random traffic including stray dones, zero lengths and clears
        for (int n = 0; n < 800; n++) begin
            clear_i = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 1) == 1)
                drive_push(rand_job(($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 50))));
            else
                push_valid_i = 0;
            job_done_i = ($urandom_range(0, 3) == 0);
            cycle();
        end
        clear_i = 0;
        drain(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
